// File: rtl/config_arb_pkg.sv
// Shared types for the configuration-port arbiter: owner encoding, FSM states, word width.
package config_arb_pkg;

  localparam int CONFIG_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    OwnerNone = 2'd0,
    OwnerSelf = 2'd1,
    OwnerUart = 2'd2,
    OwnerJtag = 2'd3
  } ownerT;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StHandover  = 3'd1,
    StGrantSelf = 3'd2,
    StGrantUart = 3'd3,
    StGrantJtag = 3'd4
  } arbStateT;

  // HANDOVER already reports its target so ConfigFSM sees the new owner during its reset pulse.
  function automatic ownerT stateOwner(arbStateT s, ownerT target);
    case (s)
      StHandover:  return target;
      StGrantSelf: return OwnerSelf;
      StGrantUart: return OwnerUart;
      StGrantJtag: return OwnerJtag;
      default:     return OwnerNone;
    endcase
  endfunction

endpackage

// File: rtl/config_arb_skid.sv
// One-entry holding register for a word that arrives while ownership is being handed over.
module config_arb_skid
  import config_arb_pkg::*;
(
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic                         load,
  input  logic                         flush,
  input  logic                         unload,
  input  logic [CONFIG_WORD_WIDTH-1:0] dataIn,
  output logic                         valid,
  output logic [CONFIG_WORD_WIDTH-1:0] data
);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        data  <= dataIn;
      end else if (flush || unload) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/config_port_arbiter.sv
// Arbitrates UART, JTAG and CPU self-writes onto the single ConfigFSM write path.
// Optional dropped-write counter is enabled with CONFIG_ARB_DROP_CNT_EN.
//   state       | meaning
//   IDLE        | no owner; JTAG > UART > self-strobe decide the next owner
//   HANDOVER    | one cycle, FsmReset pulse, target strobe goes to the skid
//   GRANT_SELF  | CPU owns the path until idle timeout or preemption
//   GRANT_UART  | UART owns the path until UartActive falls
//   GRANT_JTAG  | JTAG owns the path until JtagActive falls
module config_port_arbiter
  import config_arb_pkg::*;
#(
  parameter int SELF_IDLE_CYCLES = 1024
`ifdef CONFIG_ARB_DROP_CNT_EN
  , parameter int DROP_CNT_WIDTH = 16
`endif
) (
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic                         UartActive,
  input  logic [CONFIG_WORD_WIDTH-1:0] UartWriteData,
  input  logic                         UartWriteStrobe,
  input  logic                         JtagActive,
  input  logic [CONFIG_WORD_WIDTH-1:0] JtagWriteData,
  input  logic                         JtagWriteStrobe,
  input  logic [CONFIG_WORD_WIDTH-1:0] SelfWriteData,
  input  logic                         SelfWriteStrobe,
  output logic [CONFIG_WORD_WIDTH-1:0] ConfigWriteData,
  output logic                         ConfigWriteStrobe,
  output logic                         FsmReset,
  output logic [1:0]                   Owner,
  output logic                         Busy
`ifdef CONFIG_ARB_DROP_CNT_EN
  , output logic [DROP_CNT_WIDTH-1:0]  DropCount
`endif
);

  localparam logic [15:0] IdleLoad = 16'(SELF_IDLE_CYCLES);

  arbStateT state, stateNext;
  ownerT    target, targetNext;
  logic [15:0] idleCnt, idleCntNext;

  logic                         fwdStrobe, skidLoad, skidFlush, skidValid;
  logic [CONFIG_WORD_WIDTH-1:0] fwdData, skidData;
  logic                         strobeQ, fsmResetQ, busyQ;
  logic [CONFIG_WORD_WIDTH-1:0] dataQ;
  ownerT                        ownerQ;

  logic                         tgtActive, tgtStrobe, anyActive;
  logic [CONFIG_WORD_WIDTH-1:0] tgtData;

  assign tgtActive = (target == OwnerJtag) ? JtagActive      : UartActive;
  assign tgtStrobe = (target == OwnerJtag) ? JtagWriteStrobe : UartWriteStrobe;
  assign tgtData   = (target == OwnerJtag) ? JtagWriteData   : UartWriteData;
  assign anyActive = JtagActive | UartActive;

  always_comb begin
    stateNext   = state;
    targetNext  = target;
    idleCntNext = idleCnt;
    fwdStrobe   = 1'b0;
    fwdData     = SelfWriteData;
    skidLoad    = 1'b0;
    skidFlush   = 1'b0;
    case (state)
      StIdle: begin
        idleCntNext = '0;
        if (anyActive) begin
          stateNext  = StHandover;
          targetNext = JtagActive ? OwnerJtag : OwnerUart;
        end else if (SelfWriteStrobe) begin
          stateNext   = StGrantSelf;
          fwdStrobe   = 1'b1;
          idleCntNext = IdleLoad;
        end
      end
      StHandover: begin
        if (!tgtActive) begin
          stateNext = StIdle;
          skidFlush = 1'b1;
        end else begin
          stateNext = (target == OwnerJtag) ? StGrantJtag : StGrantUart;
          skidLoad  = tgtStrobe;
        end
      end
      StGrantSelf: begin
        if (anyActive) begin
          stateNext   = StHandover;
          targetNext  = JtagActive ? OwnerJtag : OwnerUart;
          idleCntNext = '0;
        end else if (SelfWriteStrobe) begin
          fwdStrobe   = 1'b1;
          idleCntNext = IdleLoad;
        end else if (idleCnt == 16'd1) begin
          stateNext   = StIdle;
          idleCntNext = '0;
        end else begin
          idleCntNext = idleCnt - 16'd1;
        end
      end
      StGrantUart: begin
        fwdStrobe = UartWriteStrobe;
        fwdData   = UartWriteData;
        if (!UartActive) stateNext = StIdle;
      end
      StGrantJtag: begin
        fwdStrobe = JtagWriteStrobe;
        fwdData   = JtagWriteData;
        if (!JtagActive) stateNext = StIdle;
      end
      default: stateNext = StIdle;
    endcase
  end

  // The skid word is presented straight from its register during the first GRANT cycle.
  config_arb_skid uSkid (
    .CLK    (CLK),
    .resetn (resetn),
    .load   (skidLoad),
    .flush  (skidFlush),
    .unload (skidValid),
    .dataIn (tgtData),
    .valid  (skidValid),
    .data   (skidData)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state     <= StIdle;
      target    <= OwnerNone;
      idleCnt   <= '0;
      strobeQ   <= 1'b0;
      dataQ     <= '0;
      fsmResetQ <= 1'b0;
      ownerQ    <= OwnerNone;
      busyQ     <= 1'b0;
    end else begin
      state     <= stateNext;
      target    <= targetNext;
      idleCnt   <= idleCntNext;
      strobeQ   <= fwdStrobe;
      dataQ     <= fwdStrobe ? fwdData : (skidValid ? skidData : dataQ);
      fsmResetQ <= (stateNext == StHandover);
      ownerQ    <= stateOwner(stateNext, targetNext);
      busyQ     <= (stateNext != StIdle);
    end
  end

  assign ConfigWriteStrobe = strobeQ | skidValid;
  assign ConfigWriteData   = skidValid ? skidData : dataQ;
  assign FsmReset          = fsmResetQ;
  assign Owner             = ownerQ;
  assign Busy              = busyQ;

`ifdef CONFIG_ARB_DROP_CNT_EN
  logic                    selfUsed, uartUsed, jtagUsed;
  logic [1:0]              dropNum;
  logic [DROP_CNT_WIDTH:0] dropSum;
  logic [DROP_CNT_WIDTH-1:0] dropCnt;

  assign selfUsed = ((state == StIdle) || (state == StGrantSelf)) && !anyActive;
  assign uartUsed = (state == StGrantUart) ||
                    ((state == StHandover) && (target == OwnerUart) && UartActive);
  assign jtagUsed = (state == StGrantJtag) ||
                    ((state == StHandover) && (target == OwnerJtag) && JtagActive);
  assign dropNum  = {1'b0, SelfWriteStrobe & ~selfUsed} +
                    {1'b0, UartWriteStrobe & ~uartUsed} +
                    {1'b0, JtagWriteStrobe & ~jtagUsed};
  assign dropSum  = {1'b0, dropCnt} + (DROP_CNT_WIDTH+1)'(dropNum);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) dropCnt <= '0;
    else         dropCnt <= dropSum[DROP_CNT_WIDTH] ? '1 : dropSum[DROP_CNT_WIDTH-1:0];
  end

  assign DropCount = dropCnt;
`endif

endmodule

// File: tb/tb_config_port_arbiter.sv
// Scoreboard bench for config_port_arbiter: directed sessions, expected words queued, monitor compares.
module tb_config_port_arbiter;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        UartActive, UartWriteStrobe, JtagActive, JtagWriteStrobe, SelfWriteStrobe;
  logic [31:0] UartWriteData, JtagWriteData, SelfWriteData;
  logic [31:0] ConfigWriteData;
  logic        ConfigWriteStrobe, FsmReset, Busy;
  logic [1:0]  Owner;
`ifdef CONFIG_ARB_DROP_CNT_EN
  logic [15:0] DropCount;
  logic [15:0] dropBefore;
`endif

  int checks = 0, errors = 0, monChecks = 0, monErrors = 0;
  logic [31:0] sbQ[$];

  always #5 CLK = ~CLK;

  config_port_arbiter #(.SELF_IDLE_CYCLES(4)) dut (
    .CLK(CLK), .resetn(resetn),
    .UartActive(UartActive), .UartWriteData(UartWriteData), .UartWriteStrobe(UartWriteStrobe),
    .JtagActive(JtagActive), .JtagWriteData(JtagWriteData), .JtagWriteStrobe(JtagWriteStrobe),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .ConfigWriteData(ConfigWriteData), .ConfigWriteStrobe(ConfigWriteStrobe),
    .FsmReset(FsmReset), .Owner(Owner), .Busy(Busy)
`ifdef CONFIG_ARB_DROP_CNT_EN
    , .DropCount(DropCount)
`endif
  );

  // Every emitted word must match the oldest expected word.
  always @(negedge CLK) begin
    if (ConfigWriteStrobe) begin
      monChecks++;
      if (sbQ.size() == 0) begin
        monErrors++;
        $display("FAIL unexpected_word: got %h, required no strobe", ConfigWriteData);
      end else begin
        logic [31:0] exp;
        exp = sbQ.pop_front();
        if (ConfigWriteData !== exp) begin
          monErrors++;
          $display("FAIL word_data: got %h, required %h", ConfigWriteData, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic clearStrobes();
    UartWriteStrobe = 1'b0;
    JtagWriteStrobe = 1'b0;
    SelfWriteStrobe = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    UartActive = 0; JtagActive = 0;
    clearStrobes();
    UartWriteData = '0; JtagWriteData = '0; SelfWriteData = '0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk("reset_owner", 32'(Owner), 0);
    chk("reset_busy", 32'(Busy), 0);
    chk("reset_fsmreset", 32'(FsmReset), 0);
    chk("reset_strobe", 32'(ConfigWriteStrobe), 0);
    chk("reset_data", ConfigWriteData, 0);

    // Self-only write then idle timeout.
    SelfWriteStrobe = 1; SelfWriteData = 32'hA5A5_0001; sbQ.push_back(32'hA5A5_0001);
    tick();
    clearStrobes();
    chk("self_owner", 32'(Owner), 1);
    chk("self_fsmreset", 32'(FsmReset), 0);
    chk("self_busy", 32'(Busy), 1);
    chk("self_strobe", 32'(ConfigWriteStrobe), 1);
    repeat (3) tick();
    chk("self_owner_held", 32'(Owner), 1);
    chk("self_data_held", ConfigWriteData, 32'hA5A5_0001);
    tick();
    chk("self_timeout_owner", 32'(Owner), 0);

    // UART session with a word during HANDOVER.
    UartActive = 1;
    tick();
    chk("uart_ho_fsmreset", 32'(FsmReset), 1);
    chk("uart_ho_owner", 32'(Owner), 2);
    UartWriteStrobe = 1; UartWriteData = 32'hFAB0_FAB1; sbQ.push_back(32'hFAB0_FAB1);
    JtagWriteStrobe = 1; JtagWriteData = 32'hDEAD_0001;
    tick();
    clearStrobes();
    chk("uart_grant_fsmreset", 32'(FsmReset), 0);
    chk("uart_grant_owner", 32'(Owner), 2);
    chk("uart_skid_strobe", 32'(ConfigWriteStrobe), 1);
    chk("uart_skid_data", ConfigWriteData, 32'hFAB0_FAB1);
    UartWriteStrobe = 1; UartWriteData = 32'h1111_2222; sbQ.push_back(32'h1111_2222);
    SelfWriteStrobe = 1; SelfWriteData = 32'hDEAD_0002;
    tick();
    clearStrobes();
    tick();
    chk("uart_idle_strobe", 32'(ConfigWriteStrobe), 0);
    // Last-word rule.
    UartActive = 0; UartWriteStrobe = 1; UartWriteData = 32'h1A57_0000; sbQ.push_back(32'h1A57_0000);
    tick();
    clearStrobes();
    chk("lastword_strobe", 32'(ConfigWriteStrobe), 1);
    chk("lastword_owner", 32'(Owner), 0);
    tick();

    // Preemption of a CPU session by JTAG.
    SelfWriteStrobe = 1; SelfWriteData = 32'h0000_0010; sbQ.push_back(32'h0000_0010);
    tick();
    chk("pre_self_owner", 32'(Owner), 1);
`ifdef CONFIG_ARB_DROP_CNT_EN
    dropBefore = DropCount;
`endif
    JtagActive = 1; SelfWriteStrobe = 1; SelfWriteData = 32'hBAD0_0001;
    tick();
    clearStrobes();
    chk("pre_fsmreset", 32'(FsmReset), 1);
    chk("pre_owner", 32'(Owner), 3);
    chk("pre_self_dropped", 32'(ConfigWriteStrobe), 0);
`ifdef CONFIG_ARB_DROP_CNT_EN
    chk("pre_dropcount", 32'(DropCount), 32'(dropBefore) + 1);
`endif
    tick();
    chk("pre_grant_owner", 32'(Owner), 3);
    chk("pre_grant_fsmreset", 32'(FsmReset), 0);
    JtagActive = 0;
    tick();
    chk("pre_end_owner", 32'(Owner), 0);

    // Priority tie, then UART takes over after JTAG releases.
    UartActive = 1; JtagActive = 1;
    tick();
    chk("tie_owner", 32'(Owner), 3);
    chk("tie_fsmreset", 32'(FsmReset), 1);
    tick();
    UartWriteStrobe = 1; UartWriteData = 32'hBAD0_0002;
    tick();
    clearStrobes();
    chk("tie_uart_blocked", 32'(ConfigWriteStrobe), 0);
    JtagActive = 0;
    tick();
    chk("tie_release_owner", 32'(Owner), 0);
    tick();
    chk("tie_uart_ho_owner", 32'(Owner), 2);
    chk("tie_uart_ho_fsmreset", 32'(FsmReset), 1);
    tick();
    chk("tie_uart_grant_owner", 32'(Owner), 2);
    UartActive = 0;
    tick();
    chk("tie_uart_end_owner", 32'(Owner), 0);

    // Target drops during HANDOVER: back to IDLE, word discarded.
    UartActive = 1;
    tick();
    UartActive = 0; UartWriteStrobe = 1; UartWriteData = 32'hBAD0_0003;
    tick();
    clearStrobes();
    chk("abort_owner", 32'(Owner), 0);
    chk("abort_strobe", 32'(ConfigWriteStrobe), 0);
    tick();
    chk("abort_strobe_later", 32'(ConfigWriteStrobe), 0);

    // Async reset in the first GRANT_JTAG cycle with the skid full.
    JtagActive = 1;
    tick();
    JtagWriteStrobe = 1; JtagWriteData = 32'hC0DE_0003;
    tick();
    clearStrobes();
    chk("rst_skid_strobe", 32'(ConfigWriteStrobe), 1);
    chk("rst_skid_data", ConfigWriteData, 32'hC0DE_0003);
    resetn = 0;
    #1;
    chk("rst_owner", 32'(Owner), 0);
    chk("rst_strobe", 32'(ConfigWriteStrobe), 0);
    chk("rst_fsmreset", 32'(FsmReset), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_data", ConfigWriteData, 0);
    JtagActive = 0;
    repeat (2) tick();
    resetn = 1;
    repeat (3) tick();
    chk("rst_after_strobe", 32'(ConfigWriteStrobe), 0);
    chk("rst_after_fsmreset", 32'(FsmReset), 0);
    chk("rst_after_owner", 32'(Owner), 0);

    tick();
    chk("scoreboard_empty", 32'(sbQ.size()), 0);
    checks += monChecks;
    errors += monErrors;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
